// File: rtl/hit_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : hit_detector
// Purpose  : Per-frame bullet/tank hit detection with per-tank cooldown and
//            serialised one-frame hit pulses. FRIENDLY_FIRE_EN (optional
//            macro) lets a bullet also hit the tank that fired it.
// Revision : 1.0
// ============================================================================
module hit_detector #(
  parameter int COORD_W         = 10,
  parameter int HIT_RADIUS      = 12,
  parameter int COOLDOWN_FRAMES = 30,
  parameter int MIN_GAP         = 1
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               enable,
  input  logic               bullet1_active,
  input  logic [COORD_W-1:0] bullet1_x,
  input  logic [COORD_W-1:0] bullet1_y,
  input  logic               bullet2_active,
  input  logic [COORD_W-1:0] bullet2_x,
  input  logic [COORD_W-1:0] bullet2_y,
  input  logic [COORD_W-1:0] tank1_x,
  input  logic [COORD_W-1:0] tank1_y,
  input  logic [COORD_W-1:0] tank2_x,
  input  logic [COORD_W-1:0] tank2_y,
  output logic               shot_hit1,
  output logic               shot_hit2,
  output logic               bullet1_kill,
  output logic               bullet2_kill
);

  localparam int c_CNT_W = $clog2(COOLDOWN_FRAMES + 1);
  localparam int c_GAP_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [c_CNT_W-1:0] c_COOL     = c_CNT_W'(COOLDOWN_FRAMES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_GAP_W-1:0] c_GAP      = c_GAP_W'(MIN_GAP);
  localparam logic [c_GAP_W-1:0] c_GAP_ONE  = c_GAP_W'(1);
  localparam logic [COORD_W-1:0] c_RADIUS   = COORD_W'(HIT_RADIUS);

  typedef enum logic [0:0] {
    ST_READY    = 1'b0,
    ST_COOLDOWN = 1'b1
  } state_t;

  // Index 0 refers to tank1, index 1 to tank2.
  state_t             r_state     [2];
  state_t             w_state_nxt [2];
  logic [c_CNT_W-1:0] r_cnt       [2];
  logic [c_CNT_W-1:0] w_cnt_nxt   [2];
  logic [1:0]         w_ovl;
  logic [1:0]         w_self;
  logic [1:0]         w_cond;
  logic [1:0]         w_det;
  logic [1:0]         w_req;
  logic [1:0]         r_pend;
  logic [1:0]         w_pend_nxt;
  logic [c_GAP_W-1:0] r_gap;
  logic [c_GAP_W-1:0] w_gap_nxt;
  logic [1:0]         r_hit;
  logic [1:0]         w_hit_nxt;
  logic [1:0]         r_kill;
  logic [1:0]         w_kill_nxt;

  // Unsigned distance without wrap: always subtract the smaller from the larger.
  function automatic logic f_near(input logic [COORD_W-1:0] a,
                                  input logic [COORD_W-1:0] b);
    logic [COORD_W-1:0] d;
    d = (a >= b) ? (a - b) : (b - a);
    return (d <= c_RADIUS);
  endfunction

  assign w_ovl[0] = bullet2_active && f_near(bullet2_x, tank1_x) && f_near(bullet2_y, tank1_y);
  assign w_ovl[1] = bullet1_active && f_near(bullet1_x, tank2_x) && f_near(bullet1_y, tank2_y);

`ifdef FRIENDLY_FIRE_EN
  assign w_self[0] = bullet1_active && f_near(bullet1_x, tank1_x) && f_near(bullet1_y, tank1_y);
  assign w_self[1] = bullet2_active && f_near(bullet2_x, tank2_x) && f_near(bullet2_y, tank2_y);
`else
  assign w_self = 2'b00;
`endif

  assign w_cond = w_ovl | w_self;

  always_comb begin
    w_det = 2'b00;
    for (int n = 0; n < 2; n++) begin
      w_state_nxt[n] = r_state[n];
      w_cnt_nxt[n]   = r_cnt[n];
      if (!enable) begin
        w_state_nxt[n] = ST_READY;
        w_cnt_nxt[n]   = '0;
      end else begin
        case (r_state[n])
          ST_READY: begin
            if (w_cond[n]) begin
              w_det[n]       = 1'b1;
              w_state_nxt[n] = ST_COOLDOWN;
              w_cnt_nxt[n]   = c_COOL;
            end
          end
          ST_COOLDOWN: begin
            w_cnt_nxt[n] = r_cnt[n] - c_CNT_ONE;
            if (r_cnt[n] <= c_CNT_ONE) begin
              w_state_nxt[n] = ST_READY;
              w_cnt_nxt[n]   = '0;
            end
          end
          default: begin
            w_state_nxt[n] = ST_READY;
            w_cnt_nxt[n]   = '0;
          end
        endcase
      end
    end
  end

  // A bullet is despawned by whichever tank's detection it caused.
  always_comb begin
    w_kill_nxt[0] = (w_det[1] && w_ovl[1]) || (w_det[0] && w_self[0]);
    w_kill_nxt[1] = (w_det[0] && w_ovl[0]) || (w_det[1] && w_self[1]);
  end

  // New detections compete in the same edge so an undeferred hit leaves with its kill.
  always_comb begin
    w_req      = r_pend | w_det;
    w_hit_nxt  = 2'b00;
    w_pend_nxt = w_req;
    w_gap_nxt  = (r_gap != '0) ? (r_gap - c_GAP_ONE) : '0;
    if (!enable) begin
      w_pend_nxt = 2'b00;
      w_gap_nxt  = '0;
    end else if (r_gap == '0) begin
      if (w_req[0]) begin
        w_hit_nxt[0]  = 1'b1;
        w_pend_nxt[0] = 1'b0;
        w_gap_nxt     = c_GAP;
      end else if (w_req[1]) begin
        w_hit_nxt[1]  = 1'b1;
        w_pend_nxt[1] = 1'b0;
        w_gap_nxt     = c_GAP;
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state[0] <= ST_READY;
      r_state[1] <= ST_READY;
      r_cnt[0]   <= '0;
      r_cnt[1]   <= '0;
      r_pend     <= 2'b00;
      r_gap      <= '0;
      r_hit      <= 2'b00;
      r_kill     <= 2'b00;
    end else begin
      r_state[0] <= w_state_nxt[0];
      r_state[1] <= w_state_nxt[1];
      r_cnt[0]   <= w_cnt_nxt[0];
      r_cnt[1]   <= w_cnt_nxt[1];
      r_pend     <= w_pend_nxt;
      r_gap      <= w_gap_nxt;
      r_hit      <= w_hit_nxt;
      r_kill     <= w_kill_nxt;
    end
  end

  assign shot_hit1    = r_hit[0];
  assign shot_hit2    = r_hit[1];
  assign bullet1_kill = r_kill[0];
  assign bullet2_kill = r_kill[1];

endmodule
`default_nettype wire

// File: tb/tb_hit_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_hit_detector
// Purpose  : Scoreboard bench for hit_detector; output vector is
//            {shot_hit1, shot_hit2, bullet1_kill, bullet2_kill}.
// Revision : 1.0
// ============================================================================
module tb_hit_detector;

  localparam int W = 10;

  logic         frame_clk = 1'b0;
  logic         Reset     = 1'b1;
  logic         enable    = 1'b0;
  logic         b1a = 1'b0;
  logic         b2a = 1'b0;
  logic [W-1:0] b1x = '0, b1y = '0, b2x = '0, b2y = '0;
  logic [W-1:0] t1x = W'(320), t1y = W'(240), t2x = W'(100), t2y = W'(400);
  logic         shot_hit1, shot_hit2, bullet1_kill, bullet2_kill;
  logic [3:0]   outs;

  typedef struct {
    int         cyc;
    logic [3:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   samp   = 0;

  hit_detector #(
    .COORD_W(W), .HIT_RADIUS(12), .COOLDOWN_FRAMES(30), .MIN_GAP(1)
  ) dut (
    .frame_clk      (frame_clk),
    .Reset          (Reset),
    .enable         (enable),
    .bullet1_active (b1a),
    .bullet1_x      (b1x),
    .bullet1_y      (b1y),
    .bullet2_active (b2a),
    .bullet2_x      (b2x),
    .bullet2_y      (b2y),
    .tank1_x        (t1x),
    .tank1_y        (t1y),
    .tank2_x        (t2x),
    .tank2_y        (t2y),
    .shot_hit1      (shot_hit1),
    .shot_hit2      (shot_hit2),
    .bullet1_kill   (bullet1_kill),
    .bullet2_kill   (bullet2_kill)
  );

  assign outs = {shot_hit1, shot_hit2, bullet1_kill, bullet2_kill};

  always #5 frame_clk = ~frame_clk;
  always @(posedge frame_clk) cyc <= cyc + 1;

  // Monitor: flags expected pulses that never came, then matches each visible pulse.
  always @(negedge frame_clk) begin
    if (!Reset) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse: cycle %0d expected %b, nothing seen", q[0].cyc, q[0].v);
        void'(q.pop_front());
      end
      if (outs !== 4'b0000) begin
        checks++;
        if (q.size() == 0 || q[0].cyc != cyc) begin
          errors++;
          $display("FAIL unexpected_pulse: cycle %0d got %b expected 0000", cyc, outs);
        end else begin
          if (q[0].v !== outs) begin
            errors++;
            $display("FAIL pulse_value: cycle %0d got %b expected %b", cyc, outs, q[0].v);
          end
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic expect_at(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.v   = v;
    q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Present one frame of bullet inputs; samp is the edge that samples them.
  task automatic put(input logic a1, input int x1, input int y1,
                     input logic a2, input int x2, input int y2);
    @(negedge frame_clk);
    b1a  = a1;
    b1x  = W'(x1);
    b1y  = W'(y1);
    b2a  = a2;
    b2x  = W'(x2);
    b2y  = W'(y2);
    samp = cyc + 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) put(1'b0, 0, 0, 1'b0, 0, 0);
  endtask

  initial begin
    int e0;
    repeat (3) begin
      @(negedge frame_clk);
      chk("reset_state", outs, 4'b0000);
    end
    #2 Reset = 1'b0;
    enable = 1'b1;
    idle(3);

    // Single hit: bullet2 on tank1.
    put(1'b0, 0, 0, 1'b1, 320, 240);
    expect_at(samp, 4'b1001);
    idle(40);

    // Held overlap: one hit, next only after the cooldown.
    put(1'b0, 0, 0, 1'b1, 320, 240);
    e0 = samp;
    expect_at(e0, 4'b1001);
    expect_at(e0 + 31, 4'b1001);
    for (int i = 0; i < 50; i++) put(1'b0, 0, 0, 1'b1, 320, 240);
    idle(40);

    // Simultaneous hits: shot_hit2 deferred by MIN_GAP.
    put(1'b1, 100, 400, 1'b1, 320, 240);
    expect_at(samp, 4'b1011);
    expect_at(samp + 2, 4'b0100);
    idle(40);

    // Boundary hits.
    put(1'b0, 0, 0, 1'b1, 332, 240);
    expect_at(samp, 4'b1001);
    idle(40);
    put(1'b1, 100, 388, 1'b0, 0, 0);
    expect_at(samp, 4'b0110);
    idle(40);
    put(1'b0, 0, 0, 1'b1, 308, 252);
    expect_at(samp, 4'b1001);
    idle(40);

    // Boundary misses and inactive bullet.
    put(1'b0, 0, 0, 1'b1, 333, 240);
    idle(2);
    put(1'b0, 0, 0, 1'b1, 320, 253);
    idle(2);
    put(1'b0, 0, 0, 1'b0, 320, 240);
    idle(2);

    // Bullet1 on its own tank.
    put(1'b1, 320, 240, 1'b0, 0, 0);
`ifdef FRIENDLY_FIRE_EN
    expect_at(samp, 4'b1010);
`endif
    idle(40);

    // Enable low suppresses detection.
    enable = 1'b0;
    repeat (3) put(1'b1, 100, 400, 1'b1, 320, 240);
    put(1'b0, 0, 0, 1'b0, 0, 0);
    enable = 1'b1;
    idle(2);

    // Enable drop discards the deferred hit and clears cooldowns.
    put(1'b1, 100, 400, 1'b1, 320, 240);
    expect_at(samp, 4'b1011);
    put(1'b0, 0, 0, 1'b0, 0, 0);
    enable = 1'b0;
    put(1'b0, 0, 0, 1'b0, 0, 0);
    enable = 1'b1;
    put(1'b1, 100, 400, 1'b1, 320, 240);
    expect_at(samp, 4'b1011);
    expect_at(samp + 2, 4'b0100);
    idle(40);

    // Async reset between the two simultaneous hits.
    put(1'b1, 100, 400, 1'b1, 320, 240);
    expect_at(samp, 4'b1011);
    put(1'b0, 0, 0, 1'b0, 0, 0);
    @(posedge frame_clk);
    #2 Reset = 1'b1;
    #1 chk("reset_mid_gap", outs, 4'b0000);
    #1 Reset = 1'b0;
    idle(10);

    // Async reset clears live outputs immediately.
    put(1'b0, 0, 0, 1'b1, 320, 240);
    @(posedge frame_clk);
    #1 chk("pre_reset_pulse", outs, 4'b1001);
    Reset = 1'b1;
    #1 chk("reset_immediate", outs, 4'b0000);
    b2a = 1'b0;
    #1 Reset = 1'b0;
    idle(10);

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hit_detector.md
Name: hit_detector

Overview:
- Upstream of the game state machine. Produces the one-frame `shot_hit1` and `shot_hit2` pulses that decrement the tank heart counters.
- Each frame, compares each active bullet against the opposing tank's hitbox.
- Despawns bullets that land a hit.
- Applies a per-tank invulnerability cooldown.
- Serialises hit pulses so the downstream FSM, which spends one frame in its hit state, never misses or merges a hit.

Parameters:
- COORD_W, 10, width of all x/y coordinates (pixels, unsigned).
- HIT_RADIUS, 12, maximum |dx| and |dy| in pixels at which a bullet counts as a hit on a tank centre.
- COOLDOWN_FRAMES, 30, frames a tank stays immune after being hit; the constraint COOLDOWN_FRAMES >= MIN_GAP+2 is required.
- MIN_GAP, 1, minimum low frames between any two hit pulses on either output.

Ports:
- frame_clk  in  1  frame clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- enable  in  1  high while the game is in play; low suppresses detection.
- bullet1_active  in  1  bullet fired by tank1 is on screen.
- bullet1_x, bullet1_y  in  COORD_W  tank1 bullet position.
- bullet2_active  in  1  bullet fired by tank2 is on screen.
- bullet2_x, bullet2_y  in  COORD_W  tank2 bullet position.
- tank1_x, tank1_y  in  COORD_W  tank1 centre.
- tank2_x, tank2_y  in  COORD_W  tank2 centre.
- shot_hit1  out  1  one-frame pulse: tank1 lost a heart.
- shot_hit2  out  1  one-frame pulse: tank2 lost a heart.
- bullet1_kill  out  1  one-frame pulse: despawn tank1 bullet.
- bullet2_kill  out  1  one-frame pulse: despawn tank2 bullet.

Behaviour:
- Reset is asynchronous and active-high. While Reset is high:
  - all outputs are 0;
  - pending flags are cleared;
  - cooldown counters are 0;
  - per-tank FSMs are in READY;
  - the gap counter is 0.
- Reset asserted mid-operation discards any pending hit; no pulse follows its release.
- Overlap test, combinational on sampled inputs:
  - ovl1 = bullet2_active AND |bullet2_x - tank1_x| <= HIT_RADIUS AND |bullet2_y - tank1_y| <= HIT_RADIUS.
  - ovl2 is the same test with bullet1 against tank2.
  - Absolute differences are computed in COORD_W bits without wrap (subtract the smaller value from the larger). Equality at HIT_RADIUS is a hit.
- Per-tank FSM (n = 1, 2), states READY and COOLDOWN:
  - READY: if enable and ovln are true at edge k:
    - set pending_n;
    - register the matching bullet kill high for cycle k+1 only;
    - load cooldown counter = COOLDOWN_FRAMES;
    - go to COOLDOWN.
  - COOLDOWN: overlaps are ignored (no kill, no pending). Decrement each edge; on reaching 0, return to READY.
  - Net effect: an overlap held across many frames yields exactly one hit. The next detection is possible at cycle k+COOLDOWN_FRAMES+1.
- Output arbiter:
  - Outputs are registered.
  - When the gap counter is 0 and a pending flag is set, assert that shot_hit for exactly one cycle, clear its pending flag, and load gap = MIN_GAP.
  - The gap counter decrements each cycle while nonzero.
  - Priority: pending1 before pending2.
  - shot_hit1 and shot_hit2 are never high in the same cycle.
- Latency:
  - An undeferred hit detected at edge k drives shot_hit high in cycle k+1, coincident with its kill.
  - A deferred hit keeps its kill at k+1; shot_hit fires at the first legal slot.
- Simultaneous ovl1 and ovl2:
  - both kills in cycle k+1;
  - shot_hit1 in cycle k+1;
  - shot_hit2 in cycle k+2+MIN_GAP.
- enable low:
  - no new detections;
  - pending flags and gap counter cleared;
  - cooldowns forced to 0, FSMs to READY;
  - outputs 0 from the next edge.
- An inactive bullet never hits, even when its coordinates overlap.

Optional Feature:
- Macro FRIENDLY_FIRE_EN.
- Defined: each bullet is also tested against its own tank. Tank1's hit condition is ovl1 OR (bullet1 overlaps tank1); tank2's is symmetric. When both bullets hit one tank in the same frame:
  - one pending hit;
  - both kills asserted.
- Undefined: a bullet never hits its own tank; self-overlap is ignored and the bullet is not killed.

Test Plan:
- Single hit:
  - Stimulus: bullet2_active=1 with bullet2 = tank1 = (320,240) in cycle 10 only, enable=1.
  - Response: bullet2_kill=1 and shot_hit1=1 in cycle 11 only; shot_hit2 stays 0.
- Held overlap:
  - Stimulus: overlap held from cycle 10 through cycle 60, COOLDOWN_FRAMES=30.
  - Response: shot_hit1 pulses in cycles 11 and 42 only.
- Simultaneous hits:
  - Stimulus: ovl1 and ovl2 both true in cycle 10, MIN_GAP=1.
  - Response: both kills in cycle 11; shot_hit1 in cycle 11; shot_hit2 in cycle 13; never both high together.
- Hitbox boundary:
  - Stimulus: dx=12, dy=0.
  - Response: hit.
  - Stimulus: dx=13, or dy=13, or bullet2_active=0 with zero offset.
  - Response: no kill, no shot_hit.
- Friendly fire:
  - Stimulus: bullet1 = tank1 position.
  - Response without FRIENDLY_FIRE_EN: nothing.
  - Response with FRIENDLY_FIRE_EN: bullet1_kill and shot_hit1 the next cycle.
- Reset and enable:
  - Stimulus: simultaneous hits in cycle 10; Reset pulses asynchronously mid-cycle 12.
  - Response: all outputs 0 immediately; shot_hit2 never fires.
  - Stimulus: enable=0 with an overlap.
  - Response: no outputs.
